// File: rtl/bot_seq_pkg.sv
// Shared types and constants for the Rojobot motion sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bot_seq_pkg;

    // Sequencer FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    // MotCtl value with both motors stopped
    localparam logic [7:0] IDLE_MOTCTL_DEF = 8'h00;

    // MotCtl field offsets: {lm_spd[2:0], lm_dir, rm_spd[2:0], rm_dir}
    localparam int LM_SPD_HI = 7;
    localparam int LM_SPD_LO = 5;
    localparam int LM_DIR    = 4;
    localparam int RM_SPD_HI = 3;
    localparam int RM_SPD_LO = 1;
    localparam int RM_DIR    = 0;

    // Default duration width and the matching command record
    localparam int CMD_DUR_W = 8;

    typedef struct packed {
        logic [7:0]           motctl;
        logic [CMD_DUR_W-1:0] ticks;
    } cmd_t;

endpackage

// File: rtl/bot_cmd_fifo.sv
// Show-ahead command FIFO: head entry is visible on rdat whenever !empty.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: pushes while full and pops while empty are ignored; flush empties it.
module bot_cmd_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       push,
    input  logic [W-1:0]               wdat,
    input  logic                       pop,
    output logic [W-1:0]               rdat,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    logic          do_push;
    logic          do_pop;

    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdat    = mem[rd_ptr];
    assign count   = cnt;

    // Pointer and occupancy bookkeeping; flush behaves like a reset of the queue
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Entry storage; contents need no reset because the pointers gate visibility
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdat;
    end

endmodule

// File: rtl/bot_motion_sequencer.sv
// Plays queued (MotCtl, duration) commands onto the BOT MotCtl input, one per duration.
// Latency: push into an empty idle queue reaches MotCtl 2 cycles later; outputs registered.
// Backpressure: cmd_ready drops when the queue is full or abort is asserted.
module bot_motion_sequencer
    import bot_seq_pkg::*;
#(
    parameter int         DEPTH       = 8,
    parameter int         DUR_W       = 8,
    parameter logic [7:0] IDLE_MOTCTL = IDLE_MOTCTL_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [7:0]                 cmd_motctl,
    input  logic [DUR_W-1:0]           cmd_ticks,
    input  logic                       enable,
    input  logic                       abort,
    input  logic                       upd_sysregs,
    output logic [7:0]                 MotCtl,
    output logic                       busy,
    output logic                       cmd_done,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count,
    output logic [DUR_W-1:0]           ticks_left
);
    localparam int EW = 8 + DUR_W;

    state_t           state, state_n;
    logic [7:0]       motctl_r, motctl_n;
    logic [7:0]       saved_r, saved_n;
    logic [DUR_W-1:0] ticks_r, ticks_n;
    logic             done_r, done_n;
    logic             upd_q;
    logic             tick;
    logic             push;
    logic             pop;
    logic             full;
    logic             empty;
    logic [EW-1:0]    head_dat;
    logic [7:0]       head_motctl;
    logic [DUR_W-1:0] head_ticks;
    logic             head_zero;

    assign cmd_ready   = !full && !abort;
    assign push        = cmd_valid && cmd_ready;
    assign tick        = upd_sysregs ^ upd_q;
    assign head_motctl = head_dat[EW-1 -: 8];
    assign head_ticks  = head_dat[DUR_W-1:0];
    assign head_zero   = (head_ticks == '0);

    assign MotCtl     = motctl_r;
    assign busy       = (state != IDLE);
    assign cmd_done   = done_r;
    assign ticks_left = ticks_r;

    bot_cmd_fifo #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (abort),
        .push  (push),
        .wdat  ({cmd_motctl, cmd_ticks}),
        .pop   (pop),
        .rdat  (head_dat),
        .full  (full),
        .empty (empty),
        .count (fifo_count)
    );

    // Track the update flag every cycle (reset included) so reset never creates a tick
    always_ff @(posedge clk) begin
        upd_q <= upd_sysregs;
    end

    // FSM and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            motctl_r <= IDLE_MOTCTL;
            saved_r  <= IDLE_MOTCTL;
            ticks_r  <= '0;
            done_r   <= 1'b0;
        end else begin
            state    <= state_n;
            motctl_r <= motctl_n;
            saved_r  <= saved_n;
            ticks_r  <= ticks_n;
            done_r   <= done_n;
        end
    end

    // Next-state: abort first, then pop/load, count down, pause and resume
    always_comb begin
        state_n  = state;
        motctl_n = motctl_r;
        saved_n  = saved_r;
        ticks_n  = ticks_r;
        done_n   = 1'b0;
        pop      = 1'b0;
        if (abort) begin
            state_n  = IDLE;
            motctl_n = IDLE_MOTCTL;
            ticks_n  = '0;
        end else begin
            case (state)
                IDLE: begin
                    motctl_n = IDLE_MOTCTL;
                    if (enable && !empty) begin
                        pop = 1'b1;
                        if (head_zero) begin
                            // zero-length command is consumed without touching MotCtl
                            done_n = 1'b1;
                        end else begin
                            state_n  = RUN;
                            motctl_n = head_motctl;
                            saved_n  = head_motctl;
                            ticks_n  = head_ticks;
                        end
                    end
                end
                RUN: begin
                    if (tick && ticks_r == DUR_W'(1)) begin
                        done_n   = 1'b1;
                        state_n  = IDLE;
                        motctl_n = IDLE_MOTCTL;
                        ticks_n  = '0;
                        // chain straight into the next command with no stopped gap
                        if (enable && !empty) begin
                            pop = 1'b1;
                            if (!head_zero) begin
                                state_n  = RUN;
                                motctl_n = head_motctl;
                                saved_n  = head_motctl;
                                ticks_n  = head_ticks;
                            end
                        end
                    end else begin
                        if (tick) ticks_n = ticks_r - DUR_W'(1);
                        if (!enable) begin
                            state_n  = HOLD;
                            motctl_n = IDLE_MOTCTL;
                        end
                    end
                end
                HOLD: begin
                    motctl_n = IDLE_MOTCTL;
                    if (enable) begin
                        state_n  = RUN;
                        motctl_n = saved_r;
                    end
                end
                default: begin
                    state_n  = IDLE;
                    motctl_n = IDLE_MOTCTL;
                    ticks_n  = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bot_motion_sequencer.sv
// Self-checking bench for bot_motion_sequencer: directed table, corner sequences, random vs model.
// Latency: n/a.
// Backpressure: n/a.
module tb_bot_motion_sequencer;
    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_motctl;
    logic [7:0] cmd_ticks;
    logic       enable;
    logic       abort;
    logic       upd_sysregs;
    logic [7:0] MotCtl;
    logic       busy;
    logic       cmd_done;
    logic [3:0] fifo_count;
    logic [7:0] ticks_left;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    bot_motion_sequencer #(
        .DEPTH       (DEPTH),
        .DUR_W       (8),
        .IDLE_MOTCTL (8'h00)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_motctl  (cmd_motctl),
        .cmd_ticks   (cmd_ticks),
        .enable      (enable),
        .abort       (abort),
        .upd_sysregs (upd_sysregs),
        .MotCtl      (MotCtl),
        .busy        (busy),
        .cmd_done    (cmd_done),
        .fifo_count  (fifo_count),
        .ticks_left  (ticks_left)
    );

    // Reference model: a command queue plus the active command and a paused flag
    typedef struct {
        logic [7:0] mc;
        logic [7:0] tk;
    } mcmd_t;

    mcmd_t      m_q[$];
    bit         m_active;
    bit         m_held;
    bit         m_done;
    bit         m_upd;
    logic [7:0] m_cur;
    logic [7:0] m_rem;

    function automatic logic [7:0] exp_motctl();
        return (m_active && !m_held) ? m_cur : 8'h00;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_start(input mcmd_t c);
        if (c.tk == 8'd0) begin
            m_done = 1'b1;
        end else begin
            m_active = 1'b1;
            m_held   = 1'b0;
            m_cur    = c.mc;
            m_rem    = c.tk;
        end
    endtask

    // One clock edge of the specified behaviour, using the inputs held across the edge
    task automatic model_step();
        bit    tick;
        bit    do_push;
        bit    had_cmd;
        mcmd_t c;
        mcmd_t pushed;
        tick  = upd_sysregs ^ m_upd;
        m_upd = upd_sysregs;
        if (reset || abort) begin
            m_q.delete();
            m_active = 1'b0;
            m_held   = 1'b0;
            m_rem    = 8'd0;
            m_done   = 1'b0;
            return;
        end
        do_push   = cmd_valid && (m_q.size() < DEPTH);
        pushed.mc = cmd_motctl;
        pushed.tk = cmd_ticks;
        had_cmd   = (m_q.size() != 0);
        m_done    = 1'b0;
        if (!m_active) begin
            if (enable && had_cmd) begin
                c = m_q.pop_front();
                model_start(c);
            end
        end else if (m_held) begin
            if (enable) m_held = 1'b0;
        end else if (tick && m_rem == 8'd1) begin
            m_done   = 1'b1;
            m_active = 1'b0;
            m_rem    = 8'd0;
            if (enable && had_cmd) begin
                c = m_q.pop_front();
                model_start(c);
            end
        end else begin
            if (tick) m_rem = m_rem - 8'd1;
            if (!enable) m_held = 1'b1;
        end
        if (do_push) m_q.push_back(pushed);
    endtask

    // Apply current inputs for one cycle and compare every output against the model
    task automatic cycle();
        #1;
        chk("cmd_ready", int'(cmd_ready), int'(m_q.size() < DEPTH && !abort));
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("MotCtl", int'(MotCtl), int'(exp_motctl()));
        chk("cmd_done", int'(cmd_done), int'(m_done));
        chk("busy", int'(busy), int'(m_active));
        chk("fifo_count", int'(fifo_count), m_q.size());
        chk("ticks_left", int'(ticks_left), int'(m_rem));
    endtask

    task automatic drive(input bit v, input logic [7:0] mc, input logic [7:0] tk,
                         input bit en, input bit ab, input bit up);
        cmd_valid   = v;
        cmd_motctl  = mc;
        cmd_ticks   = tk;
        enable      = en;
        abort       = ab;
        upd_sysregs = up;
    endtask

    typedef struct {
        logic       v;
        logic [7:0] mc;
        logic [7:0] tk;
        logic       en;
        logic       ab;
        logic       up;
        logic [7:0] emc;
        logic       edone;
        logic       ebusy;
        int         ecnt;
    } vec_t;

    vec_t vt[13];

    initial begin
        // Basic run (A6 for 3 ticks) then back-to-back 22 -> EE with no stopped gap
        vt[0]  = '{1'b1, 8'hA6, 8'd3, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1};
        vt[1]  = '{1'b0, 8'h00, 8'd0, 1'b1, 1'b0, 1'b0, 8'hA6, 1'b0, 1'b1, 0};
        vt[2]  = '{1'b0, 8'h00, 8'd0, 1'b1, 1'b0, 1'b1, 8'hA6, 1'b0, 1'b1, 0};
        vt[3]  = '{1'b0, 8'h00, 8'd0, 1'b1, 1'b0, 1'b1, 8'hA6, 1'b0, 1'b1, 0};
        vt[4]  = '{1'b0, 8'h00, 8'd0, 1'b1, 1'b0, 1'b0, 8'hA6, 1'b0, 1'b1, 0};
        vt[5]  = '{1'b0, 8'h00, 8'd0, 1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 0};
        vt[6]  = '{1'b0, 8'h00, 8'd0, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 0};
        vt[7]  = '{1'b1, 8'h22, 8'd2, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1};
        vt[8]  = '{1'b1, 8'hEE, 8'd1, 1'b1, 1'b0, 1'b1, 8'h22, 1'b0, 1'b1, 1};
        vt[9]  = '{1'b0, 8'h00, 8'd0, 1'b1, 1'b0, 1'b0, 8'h22, 1'b0, 1'b1, 1};
        vt[10] = '{1'b0, 8'h00, 8'd0, 1'b1, 1'b0, 1'b1, 8'hEE, 1'b1, 1'b1, 0};
        vt[11] = '{1'b0, 8'h00, 8'd0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 0};
        vt[12] = '{1'b0, 8'h00, 8'd0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 0};

        reset = 1'b1;
        drive(1'b0, 8'h00, 8'd0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        m_q.delete();
        m_active = 1'b0;
        m_held   = 1'b0;
        m_done   = 1'b0;
        m_rem    = 8'd0;
        m_cur    = 8'd0;
        m_upd    = upd_sysregs;
        @(negedge clk);
        chk("rst_motctl", int'(MotCtl), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_count", int'(fifo_count), 0);
        chk("rst_done", int'(cmd_done), 0);
        chk("rst_ticks_left", int'(ticks_left), 0);
        reset = 1'b0;

        for (int i = 0; i < 13; i++) begin
            drive(vt[i].v, vt[i].mc, vt[i].tk, vt[i].en, vt[i].ab, vt[i].up);
            cycle();
            chk($sformatf("vec%0d_motctl", i), int'(MotCtl), int'(vt[i].emc));
            chk($sformatf("vec%0d_done", i), int'(cmd_done), int'(vt[i].edone));
            chk($sformatf("vec%0d_busy", i), int'(busy), int'(vt[i].ebusy));
            chk($sformatf("vec%0d_count", i), int'(fifo_count), vt[i].ecnt);
        end

        // Fill while paused: 9 pushes, only 8 fit; first entry is zero-length
        drive(1'b1, 8'h44, 8'd0, 1'b0, 1'b0, 1'b0);
        cycle();
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 8'h10 + 8'(i), 8'd2, 1'b0, 1'b0, 1'b0);
            cycle();
        end
        chk("fill_count", int'(fifo_count), 8);
        chk("fill_ready", int'(cmd_ready), 0);
        drive(1'b0, 8'h00, 8'd0, 1'b1, 1'b0, 1'b0);
        cycle();
        chk("zero_done", int'(cmd_done), 1);
        chk("zero_motctl", int'(MotCtl), 0);
        chk("zero_busy", int'(busy), 0);
        chk("zero_count", int'(fifo_count), 7);
        cycle();
        chk("after_zero_motctl", int'(MotCtl), 8'h11);

        // Abort mid-RUN with a simultaneous push
        drive(1'b0, 8'h00, 8'd0, 1'b1, 1'b1, 1'b0);
        cycle();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 8'h30 + 8'(i), 8'd3, 1'b0, 1'b0, 1'b0);
            cycle();
        end
        drive(1'b0, 8'h00, 8'd0, 1'b1, 1'b0, 1'b0);
        cycle();
        drive(1'b0, 8'h00, 8'd0, 1'b1, 1'b0, 1'b1);
        cycle();
        chk("pre_abort_motctl", int'(MotCtl), 8'h30);
        drive(1'b1, 8'h99, 8'd2, 1'b1, 1'b1, 1'b1);
        cycle();
        chk("abort_motctl", int'(MotCtl), 0);
        chk("abort_count", int'(fifo_count), 0);
        chk("abort_done", int'(cmd_done), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_ticks_left", int'(ticks_left), 0);
        drive(1'b0, 8'h00, 8'd0, 1'b1, 1'b0, 1'b1);
        cycle();
        chk("abort_push_lost", int'(fifo_count), 0);
        chk("abort_stays_idle", int'(MotCtl), 0);

        // Pause: one tick, drop enable, 5 ignored toggles, resume, 3 more ticks
        drive(1'b1, 8'h66, 8'd4, 1'b1, 1'b0, 1'b1);
        cycle();
        drive(1'b0, 8'h00, 8'd0, 1'b1, 1'b0, 1'b1);
        cycle();
        drive(1'b0, 8'h00, 8'd0, 1'b1, 1'b0, 1'b0);
        cycle();
        drive(1'b0, 8'h00, 8'd0, 1'b0, 1'b0, 1'b0);
        cycle();
        chk("hold_motctl", int'(MotCtl), 0);
        chk("hold_ticks_left", int'(ticks_left), 3);
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 8'h00, 8'd0, 1'b0, 1'b0, ~upd_sysregs);
            cycle();
        end
        chk("hold_frozen", int'(ticks_left), 3);
        chk("hold_busy", int'(busy), 1);
        drive(1'b0, 8'h00, 8'd0, 1'b1, 1'b0, upd_sysregs);
        cycle();
        chk("resume_motctl", int'(MotCtl), 8'h66);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 8'h00, 8'd0, 1'b1, 1'b0, ~upd_sysregs);
            cycle();
            if (i == 1) chk("resume_mid_motctl", int'(MotCtl), 8'h66);
        end
        chk("resume_done", int'(cmd_done), 1);
        chk("resume_end_motctl", int'(MotCtl), 0);

        // Reset mid-RUN with the update flag changing during reset
        drive(1'b1, 8'hA6, 8'd5, 1'b1, 1'b0, 1'b0);
        cycle();
        drive(1'b0, 8'h00, 8'd0, 1'b1, 1'b0, 1'b0);
        cycle();
        chk("pre_reset_motctl", int'(MotCtl), 8'hA6);
        reset = 1'b1;
        drive(1'b0, 8'h00, 8'd0, 1'b1, 1'b0, 1'b1);
        cycle();
        chk("reset_motctl", int'(MotCtl), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_count", int'(fifo_count), 0);
        reset = 1'b0;
        drive(1'b1, 8'h5A, 8'd1, 1'b1, 1'b0, 1'b1);
        cycle();
        drive(1'b0, 8'h00, 8'd0, 1'b1, 1'b0, 1'b1);
        cycle();
        cycle();
        chk("no_spurious_tick", int'(MotCtl), 8'h5A);
        drive(1'b0, 8'h00, 8'd0, 1'b1, 1'b0, 1'b0);
        cycle();
        chk("post_reset_done", int'(cmd_done), 1);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 199) == 0);
            drive(($urandom_range(0, 1) == 1), 8'($urandom), 8'($urandom_range(0, 4)),
                  ($urandom_range(0, 99) < 85), ($urandom_range(0, 99) < 3),
                  ($urandom_range(0, 99) < 40) ? ~upd_sysregs : upd_sysregs);
            cycle();
        end
        reset = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bot_motion_sequencer.md
Name: bot_motion_sequencer

Overview:
Schedules Rojobot motor commands so the system does not hand-drive the MotCtl register.
- Software or an application FSM pushes (MotCtl value, duration) commands into a small queue.
- The block drives each command onto MotCtl for the requested number of BOT update periods, then advances to the next command.
- One BOT update period is one toggle of upd_sysregs.
- Sits between the application and the BOT MotCtl input; abort and pause provide safe stopping.

Parameters:
DEPTH, 8, command queue depth (power of 2, ≥2)
DUR_W, 8, width of the duration field in update ticks
IDLE_MOTCTL, 8'h00, MotCtl value driven when no command is active (both motors stopped)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
cmd_valid  in  1  push request
cmd_ready  out  1  queue can accept (push occurs when cmd_valid & cmd_ready)
cmd_motctl  in  8  {lm_spd[2:0], lm_dir, rm_spd[2:0], rm_dir}
cmd_ticks  in  DUR_W  duration in upd_sysregs toggles
enable  in  1  1 = run queue; 0 = pause
abort  in  1  flush queue and stop immediately
upd_sysregs  in  1  BOT update toggle flag
MotCtl  out  8  motor control to BOT
busy  out  1  state != IDLE
cmd_done  out  1  one-cycle pulse when a command completes (not on abort)
fifo_count  out  $clog2(DEPTH+1)  queued entries, excluding the active command
ticks_left  out  DUR_W  remaining ticks of the active command

Behaviour:
- Reset (synchronous): state=IDLE, queue empty, MotCtl=IDLE_MOTCTL, busy=0, cmd_done=0, ticks_left=0, upd_q<=upd_sysregs.
- tick = upd_sysregs ^ upd_q. upd_q is registered every cycle. Either toggle direction counts as one tick.
- cmd_ready = !full & !abort. A push and pop in the same cycle are legal. When full there is no bypass.
- States: IDLE, RUN, HOLD. All outputs are registered.
- IDLE:
  - MotCtl=IDLE_MOTCTL.
  - If enable & !empty & !abort: pop the head. If ticks≠0, go to RUN next cycle with MotCtl=head.motctl and ticks_left=head.ticks.
  - Latency from push into an empty idle queue to MotCtl change: 2 cycles.
- ticks=0 command: popped and discarded. cmd_done pulses the next cycle; MotCtl is never changed; state stays IDLE.
- RUN:
  - A tick decrements ticks_left.
  - On tick with ticks_left==1, the command completes: cmd_done=1 next cycle.
  - If at completion enable & !empty: pop the next command in the same cycle and load it directly. There is no IDLE_MOTCTL gap; a next command with ticks=0 is discarded and the state goes to IDLE.
  - Otherwise go to IDLE with MotCtl=IDLE_MOTCTL next cycle.
- RUN & !enable (and not completing this cycle): go to HOLD. MotCtl=IDLE_MOTCTL, ticks_left frozen, ticks ignored.
- HOLD & enable: return to RUN. MotCtl restores the saved command value next cycle, and counting resumes.
- abort, in any state, has highest priority:
  - Next cycle: queue empty, state IDLE, MotCtl=IDLE_MOTCTL, ticks_left=0, no cmd_done.
  - A push in the abort cycle is dropped.
- Completion and abort in the same cycle: abort wins, no cmd_done.
- enable low in IDLE: nothing pops; pushes are still accepted.
- fifo_count wraps nowhere: it saturates at DEPTH by construction (cmd_ready=0).

Decomposition:
- Package bot_seq_pkg:
  - state enum {IDLE, RUN, HOLD}
  - IDLE_MOTCTL default
  - MotCtl field offsets (LM_SPD=7:5, LM_DIR=4, RM_SPD=3:1, RM_DIR=0)
  - command struct {motctl[7:0], ticks[DUR_W-1:0]}
- Sub-module bot_cmd_fifo: synchronous show-ahead FIFO with push, pop, full, empty, count, and flush (used by abort).
- FSM, tick detection and tick counter live in the top module.

Test Plan:
- Basic run: push (8'hA6, 3), enable=1 → MotCtl=8'hA6 two cycles after push, held for exactly 3 upd_sysregs toggles, then 8'h00; one cmd_done pulse.
- Back-to-back: push (8'h22,2), (8'hEE,1) → MotCtl goes 22→EE with no 00 cycle between; two cmd_done pulses; ends at 00, busy=0.
- Fill and zero-duration: push 9 commands with DEPTH=8, enable=0 → cmd_ready=0 after 8, fifo_count=8. Enable with the first command (8'h44,0) → discarded, MotCtl stays 00, cmd_done pulses.
- Pause: running (8'h66,4), drop enable after 1 tick, toggle upd_sysregs 5 times → MotCtl=00, ticks_left=3 frozen. Re-enable → MotCtl=66, completes after 3 more ticks.
- Abort: queue 4 commands, abort mid-RUN together with a push → next cycle MotCtl=00, fifo_count=0, no cmd_done, pushed entry lost.
- Reset mid-RUN with MotCtl=8'hA6 → next cycle MotCtl=00, busy=0, fifo_count=0. No spurious tick is counted if upd_sysregs differs from its pre-reset value.
